seg7_bcd_counter: RTL and testbench

Parametrised multi-digit BCD counter with a time-multiplexed seven-segment display driver. It is the next generation of the single 8-bit start/stop counter block. It adds configurable digit count, a tick prescaler, up/down mode, synchronous clear and parallel load, a terminal-count pulse, and digit scanning. It sits between the top-level pin map and the display pins: control comes from dedicated inputs, and segments and digit enables drive bidirectional outputs.

---
 rtl/seg7_bcd_counter.sv | 184 ++++++++++++++++++
 tb/tb_seg7_bcd_counter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seg7_bcd_counter.sv
// Multi-digit BCD up/down counter with prescaler, parallel load and a scanned 7-segment driver.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_bcd_counter #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned SCAN_DIV = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PcntMax = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] ScntMax = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IdxMax  = IW'(DIGITS - 1);

  logic [CW-1:0] count_q, count_d;
  logic          tc_q, tc_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic          tick;
  logic [CW-1:0] inc_val, dec_val, sat_val;
  logic          carry, borrow;
  logic [3:0]    sel_digit;
  logic          sel_blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign tick = run & (pcnt_q == PcntMax);

  // Ripple increment/decrement; a carry/borrow out of the top digit is the wrap.
  always_comb begin
    inc_val = '0;
    dec_val = '0;
    sat_val = '0;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (count_q[i*4 +: 4] >= 4'd9) begin
          inc_val[i*4 +: 4] = 4'd0;
        end else begin
          inc_val[i*4 +: 4] = count_q[i*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end else begin
        inc_val[i*4 +: 4] = count_q[i*4 +: 4];
      end
      if (borrow) begin
        if (count_q[i*4 +: 4] == 4'd0) begin
          dec_val[i*4 +: 4] = 4'd9;
        end else begin
          dec_val[i*4 +: 4] = count_q[i*4 +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end else begin
        dec_val[i*4 +: 4] = count_q[i*4 +: 4];
      end
      sat_val[i*4 +: 4] = (load_val[i*4 +: 4] > 4'd9) ? 4'd9 : load_val[i*4 +: 4];
    end
  end

  always_comb begin
    count_d = count_q;
    pcnt_d  = pcnt_q;
    tc_d    = 1'b0;
    if (clear) begin
      count_d = '0;
      pcnt_d  = '0;
    end else if (load) begin
      count_d = sat_val;
      pcnt_d  = '0;
    end else if (run) begin
      pcnt_d = (pcnt_q == PcntMax) ? '0 : pcnt_q + PW'(1);
      if (tick) begin
        count_d = up ? inc_val : dec_val;
        tc_d    = up ? carry : borrow;
      end
    end
  end

  // Scan runs free; clear and load never disturb it.
  always_comb begin
    scnt_d = scnt_q;
    idx_d  = idx_q;
    if (scnt_q == ScntMax) begin
      scnt_d = '0;
      idx_d  = (idx_q == IdxMax) ? '0 : idx_q + IW'(1);
    end else begin
      scnt_d = scnt_q + SW'(1);
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank;
  logic              zero_above;

  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_above = zero_above & (count_q[i*4 +: 4] == 4'd0);
      blank[i]   = zero_above;
    end
  end
`endif

  always_comb begin
    sel_digit = '0;
    sel_blank = 1'b0;
    an_d      = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      an_d[i] = (idx_q == IW'(i));
      if (idx_q == IW'(i)) begin
        sel_digit = count_q[i*4 +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        sel_blank = blank[i];
`else
        sel_blank = 1'b0;
`endif
      end
    end
    seg_d = sel_blank ? 7'h00 : decode(sel_digit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      pcnt_q  <= '0;
      scnt_q  <= '0;
      idx_q   <= '0;
      seg_q   <= 7'h00;
      an_q    <= '0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      pcnt_q  <= pcnt_d;
      scnt_q  <= scnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign seg   = seg_q;
  assign an    = an_q;

endmodule

// File: tb/tb_seg7_bcd_counter.sv
// Directed bench for seg7_bcd_counter: a PRESCALE=1 instance for most steps and a
// PRESCALE=3 instance for the prescaler/hold sequence.
module tb_seg7_bcd_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0, up = 1'b1, clear = 1'b0, load = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] count;
  logic        tc;
  logic [6:0]  seg;
  logic [3:0]  an;

  logic        run3 = 1'b0, up3 = 1'b1, clear3 = 1'b0, load3 = 1'b0;
  logic [15:0] load_val3 = '0;
  logic [15:0] count3;
  logic        tc3;
  logic [6:0]  seg3;
  logic [3:0]  an3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seg7_bcd_counter #(.DIGITS(4), .PRESCALE(1), .SCAN_DIV(2)) u_dut (
    .clk(clk), .rst(rst), .run(run), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .count(count), .tc(tc), .seg(seg), .an(an)
  );

  seg7_bcd_counter #(.DIGITS(4), .PRESCALE(3), .SCAN_DIV(2)) u_dut_p3 (
    .clk(clk), .rst(rst), .run(run3), .up(up3), .clear(clear3), .load(load3),
    .load_val(load_val3), .count(count3), .tc(tc3), .seg(seg3), .an(an3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [6:0] seg_tbl [4];
  logic [3:0] prev_an;
  bit         synced;

  initial begin
    // Reset for two cycles
    step(); step();
    chk("rst_count", count, 32'h0);
    chk("rst_tc", tc, 0);
    chk("rst_an", an, 0);
    chk("rst_seg", seg, 0);
    rst = 1'b0;
    step();
    chk("rel_an", an, 4'b0001);
    chk("rel_seg", seg, 7'h3F);
    step();
    chk("rel_an2", an, 4'b0001);
    step();
    chk("rel_an3", an, 4'b0010);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    chk("rel_seg_d1", seg, 7'h00);
`else
    chk("rel_seg_d1", seg, 7'h3F);
`endif

    // Up wrap
    load_val = 16'h9998; load = 1'b1;
    step();
    chk("up_load", count, 32'h9998);
    load = 1'b0; run = 1'b1; up = 1'b1;
    step();
    chk("up_9999", count, 32'h9999);
    chk("up_9999_tc", tc, 0);
    step();
    chk("up_wrap", count, 32'h0000);
    chk("up_wrap_tc", tc, 1);
    step();
    chk("up_0001", count, 32'h0001);
    chk("up_0001_tc", tc, 0);
    run = 1'b0;

    // Saturating load then down wrap
    load_val = 16'hFFFF; load = 1'b1;
    step();
    chk("sat_load", count, 32'h9999);
    load_val = 16'h0001;
    step();
    chk("dn_load", count, 32'h0001);
    load = 1'b0; up = 1'b0; run = 1'b1;
    step();
    chk("dn_0000", count, 32'h0000);
    chk("dn_0000_tc", tc, 0);
    step();
    chk("dn_wrap", count, 32'h9999);
    chk("dn_wrap_tc", tc, 1);
    run = 1'b0;
    step();
    chk("dn_hold", count, 32'h9999);
    chk("dn_hold_tc", tc, 0);

    // Priority: clear beats load beats a wrapping tick
    run = 1'b1; up = 1'b1; clear = 1'b1; load = 1'b1; load_val = 16'h1234;
    step();
    chk("pri_clear", count, 32'h0000);
    chk("pri_clear_tc", tc, 0);
    clear = 1'b0;
    step();
    chk("pri_load", count, 32'h1234);
    chk("pri_load_tc", tc, 0);
    load = 1'b0; run = 1'b0;

    // Prescaler = 3: ticks on run-cycles 3 and 6, hold, then pcnt resumes from 1
    run3 = 1'b1; up3 = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      chk($sformatf("ps_run%0d", c), count3, (c >= 6) ? 32'h2 : (c >= 3) ? 32'h1 : 32'h0);
    end
    run3 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      step();
      chk($sformatf("ps_hold%0d", c), count3, 32'h2);
    end
    run3 = 1'b1;
    step();
    chk("ps_resume1", count3, 32'h2);
    step();
    chk("ps_resume2", count3, 32'h3);
    run3 = 1'b0;

    // Scan of 1234: wait for digit 0 to start its dwell, then walk all digits
    seg_tbl[0] = 7'h66; seg_tbl[1] = 7'h4F; seg_tbl[2] = 7'h5B; seg_tbl[3] = 7'h06;
    synced  = 1'b0;
    prev_an = an;
    for (int c = 0; c < 20 && !synced; c++) begin
      step();
      if (an == 4'b0001 && prev_an == 4'b1000) synced = 1'b1;
      prev_an = an;
    end
    chk("scan_sync", {31'h0, synced}, 32'h1);
    if (synced) begin
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("scan_an%0d", k), an, 32'(4'b0001 << (k / 2)));
        chk($sformatf("scan_seg%0d", k), seg, seg_tbl[k / 2]);
        step();
      end
      chk("scan_return", an, 4'b0001);
      chk("scan_return_seg", seg, 7'h66);
    end

    // Reset mid-operation
    run = 1'b1; rst = 1'b1;
    step();
    chk("mid_rst_count", count, 32'h0);
    chk("mid_rst_an", an, 0);
    chk("mid_rst_seg", seg, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
